// File: rtl/la_ioring_seq.sv
// la_ioring_seq: timed power-up/down sequencer for a segmented io ring, 4-phase req/ack
module la_ioring_seq #(
  parameter int NSEG  = 4,
  parameter int RINGW = 8,
  parameter int CNTW  = 8
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  pwr_req,
  input  logic [CNTW-1:0]       dly,
  output logic                  pwr_ack,
  output logic                  busy,
  output logic [NSEG-1:0]       seg_on,
  output logic [NSEG*RINGW-1:0] ioring
);
  localparam int NPOS = 4 * NSEG;
  localparam int PW = $clog2(NPOS);
  localparam logic [PW-1:0] LAST = PW'(NPOS - 1);
  typedef enum logic [1:0] {OFF, UP, ON, DOWN} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] pos, pos_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic [NPOS-1:0] ctl, ctl_nxt;
  logic [NSEG-1:0] seg_nxt;
  logic [1:0] rs;
  logic rst_s;
  // reset synchronizer: asserts with nreset, releases two edges later
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) rs <= '0;
    else rs <= {rs[0], 1'b1};
  assign rst_s = rs[1];
  // next state: pos is the most recently changed ctrl bit, cnt the remaining hold
  always_comb begin
    state_nxt = state;
    pos_nxt = pos;
    cnt_nxt = cnt;
    ctl_nxt = ctl;
    case (state)
      OFF:
        if (pwr_req) begin
          state_nxt = UP;
          pos_nxt = '0;
          ctl_nxt[0] = 1'b1;
          cnt_nxt = dly;
        end
      UP:
        if (!pwr_req) begin
          state_nxt = DOWN;
          ctl_nxt[pos] = 1'b0;
          cnt_nxt = dly;
        end else if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else if (pos != LAST) begin
          pos_nxt = pos + 1'b1;
          ctl_nxt[pos_nxt] = 1'b1;
          cnt_nxt = dly;
        end else state_nxt = ON;
      ON:
        if (!pwr_req) begin
          state_nxt = DOWN;
          ctl_nxt[LAST] = 1'b0;
          cnt_nxt = dly;
        end
      DOWN:
        if (pwr_req) begin
          state_nxt = UP;
          ctl_nxt[pos] = 1'b1;
          cnt_nxt = dly;
        end else if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else if (pos != '0) begin
          pos_nxt = pos - 1'b1;
          ctl_nxt[pos_nxt] = 1'b0;
          cnt_nxt = dly;
        end else state_nxt = OFF;
      default: state_nxt = OFF;
    endcase
  end
  // segment fully on decode of the next ctrl bits, so seg_on lines up with ioring
  always_comb begin
    seg_nxt = '0;
    for (int i = 0; i < NSEG; i++) seg_nxt[i] = &ctl_nxt[4*i +: 4];
  end
  // state, pointer, hold counter and all registered outputs
  always_ff @(posedge clk or negedge rst_s)
    if (!rst_s) begin
      state <= OFF;
      pos <= '0;
      cnt <= '0;
      ctl <= '0;
      seg_on <= '0;
      pwr_ack <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_nxt;
      pos <= pos_nxt;
      cnt <= cnt_nxt;
      ctl <= ctl_nxt;
      seg_on <= seg_nxt;
      pwr_ack <= state_nxt == ON;
      busy <= state_nxt == UP || state_nxt == DOWN;
    end
  // spread the 4 ctrl bits of each segment into its ring word, upper bits tied low
  always_comb begin
    ioring = '0;
    for (int i = 0; i < NSEG; i++) ioring[i*RINGW +: 4] = ctl[4*i +: 4];
  end
endmodule

// File: tb/tb_la_ioring_seq.sv
// tb_la_ioring_seq: vector table, hand sequences and randomized run against a level-count model
module tb_la_ioring_seq;
  localparam int NSEG = 4, RINGW = 8, CNTW = 8, NPOS = 16;
  logic clk = 0, nreset = 1, pwr_req = 0;
  logic [CNTW-1:0] dly = '0;
  logic pwr_ack, busy;
  logic [NSEG-1:0] seg_on;
  logic [NSEG*RINGW-1:0] ioring;
  int checks = 0, failures = 0;
  int m_mode = 0, m_n = 0, m_r = 0, m_rel = 0;

  la_ioring_seq #(.NSEG(NSEG), .RINGW(RINGW), .CNTW(CNTW)) dut (
    .clk(clk), .nreset(nreset), .pwr_req(pwr_req), .dly(dly),
    .pwr_ack(pwr_ack), .busy(busy), .seg_on(seg_on), .ioring(ioring)
  );

  always #5 clk = ~clk;

  // model: m_n = number of ctrl bits set (always a prefix of the step order);
  // m_mode 0 off, 1 rising, 2 on, 3 falling; m_r = hold cycles left
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_mode = 0; m_n = 0; m_r = 0; m_rel = 0;
    end else if (m_rel < 2) m_rel++;
    else case (m_mode)
      0: if (pwr_req) begin m_mode = 1; m_n = 1; m_r = int'(dly); end
      1: if (!pwr_req) begin m_mode = 3; m_n--; m_r = int'(dly); end
         else if (m_r > 0) m_r--;
         else if (m_n < NPOS) begin m_n++; m_r = int'(dly); end
         else m_mode = 2;
      2: if (!pwr_req) begin m_mode = 3; m_n--; m_r = int'(dly); end
      3: if (pwr_req) begin m_mode = 1; m_n++; m_r = int'(dly); end
         else if (m_r > 0) m_r--;
         else if (m_n > 0) begin m_n--; m_r = int'(dly); end
         else m_mode = 0;
      default: ;
    endcase
  end

  function automatic logic [31:0] ring_of(input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r[(i / 4) * RINGW + i % 4] = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] seg_of(input int n);
    logic [3:0] s = '0;
    for (int i = 0; i < NSEG; i++) s[i] = n >= 4 * (i + 1);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] er, input logic [3:0] es, input logic ea, input logic eb);
    checks += 4;
    if (ioring !== er) begin failures++; $display("FAIL %s ioring got=%h exp=%h", tag, ioring, er); end
    if (seg_on !== es) begin failures++; $display("FAIL %s seg_on got=%b exp=%b", tag, seg_on, es); end
    if (pwr_ack !== ea) begin failures++; $display("FAIL %s pwr_ack got=%b exp=%b", tag, pwr_ack, ea); end
    if (busy !== eb) begin failures++; $display("FAIL %s busy got=%b exp=%b", tag, busy, eb); end
  endtask

  task automatic chk_model(input string tag);
    chk(tag, ring_of(m_n), seg_of(m_n), m_mode == 2, m_mode == 1 || m_mode == 3);
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic req; int d; int n;
    logic [31:0] ring; logic [3:0] seg; logic ack; logic bsy;
  } vec_t;
  vec_t tbl[16];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1, 0, 1,  32'h00000001, 4'b0000, 0, 1};
    tbl[1]  = '{1, 0, 3,  32'h0000000F, 4'b0001, 0, 1};
    tbl[2]  = '{1, 0, 1,  32'h0000010F, 4'b0001, 0, 1};
    tbl[3]  = '{1, 0, 11, 32'h0F0F0F0F, 4'b1111, 0, 1};
    tbl[4]  = '{1, 0, 1,  32'h0F0F0F0F, 4'b1111, 1, 0};
    tbl[5]  = '{1, 7, 5,  32'h0F0F0F0F, 4'b1111, 1, 0};
    tbl[6]  = '{0, 0, 1,  32'h070F0F0F, 4'b0111, 0, 1};
    tbl[7]  = '{0, 0, 14, 32'h00000001, 4'b0000, 0, 1};
    tbl[8]  = '{0, 0, 1,  32'h00000000, 4'b0000, 0, 1};
    tbl[9]  = '{0, 0, 1,  32'h00000000, 4'b0000, 0, 0};
    tbl[10] = '{1, 3, 1,  32'h00000001, 4'b0000, 0, 1};
    tbl[11] = '{1, 3, 3,  32'h00000001, 4'b0000, 0, 1};
    tbl[12] = '{1, 3, 1,  32'h00000003, 4'b0000, 0, 1};
    tbl[13] = '{1, 3, 58, 32'h0F0F0F0F, 4'b1111, 0, 1};
    tbl[14] = '{1, 3, 1,  32'h0F0F0F0F, 4'b1111, 0, 1};
    tbl[15] = '{1, 3, 1,  32'h0F0F0F0F, 4'b1111, 1, 0};
    #1 nreset = 0;
    #11 chk("reset", '0, '0, 0, 0);
    nreset = 1;
    cyc(3);
    chk("post_release_idle", '0, '0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      pwr_req = tbl[i].req;
      dly = CNTW'(tbl[i].d);
      cyc(tbl[i].n);
      chk($sformatf("vec%0d", i), tbl[i].ring, tbl[i].seg, tbl[i].ack, tbl[i].bsy);
      chk_model($sformatf("vec%0d_model", i));
    end
    // asynchronous reset while ON, then restart with the request already high
    dly = '0;
    #2 nreset = 0;
    #1 chk("async_reset", '0, '0, 0, 0);
    nreset = 1;
    for (int i = 0; i < 8 && ioring == '0; i++) cyc(1);
    chk("restart_seg0_b0", 32'h00000001, 4'b0000, 0, 1);
    // abort after seg1 b1 is set
    cyc(5);
    chk("abort_pre", 32'h0000030F, 4'b0001, 0, 1);
    pwr_req = 0;
    cyc(1);
    chk("abort_seg1b1_cleared", 32'h0000010F, 4'b0001, 0, 1);
    cyc(1);
    chk("abort_seg1b0_cleared", 32'h0000000F, 4'b0001, 0, 1);
    cyc(1);
    chk("abort_seg0b3_cleared", 32'h00000007, 4'b0000, 0, 1);
    cyc(3);
    chk("abort_all_clear", '0, '0, 0, 1);
    cyc(1);
    chk("abort_off", '0, '0, 0, 0);
    // resume after seg2 b2 is cleared
    pwr_req = 1;
    cyc(17);
    chk("resume_on", 32'h0F0F0F0F, 4'b1111, 1, 0);
    pwr_req = 0;
    cyc(6);
    chk("resume_pre", 32'h00030F0F, 4'b0011, 0, 1);
    pwr_req = 1;
    cyc(1);
    chk("resume_seg2b2_set", 32'h00070F0F, 4'b0011, 0, 1);
    cyc(5);
    chk("resume_top", 32'h0F0F0F0F, 4'b1111, 0, 1);
    cyc(1);
    chk("resume_ack", 32'h0F0F0F0F, 4'b1111, 1, 0);
    chk_model("resume_model");
    // randomized run against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 23) == 0) pwr_req = ~pwr_req;
      if ($urandom_range(0, 7) == 0) dly = CNTW'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) begin
        nreset = 0;
        #1 chk_model("rand_reset");
        #1 nreset = 1;
      end
      cyc(1);
      chk_model($sformatf("rand%0d", i));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
